multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset.
REQ-004 Opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 Zero  input  1  ALU zero flag, used in BRANCH.
REQ-006 MemReady  input  1  memory access complete in the current cycle.
REQ-007 PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, IorD, ALUSrcA, PCSource  output  1 each  datapath controls.
REQ-008 ALUSrcB  output  2  ALU B select: 00 reg, 01 constant 4, 10 immediate, 11 branch offset.
REQ-009 ALUOp  output  2  to the ALU control decoder: 00 add, 01 subtract, 10 use funct fields.
REQ-010 Illegal  output  1  sticky unsupported-opcode flag.
REQ-011 InstRet  output  32  retired-instruction count.
REQ-012 State  output  4  current state, for debug.

Function
REQ-013 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8; codes 9-15 SHALL go to FETCH on the next edge.
REQ-014 Supported opcodes: R-type 0110011, lw 0000011, sw 0100011, beq 1100011.
REQ-015 FETCH SHALL hold while MemReady=0 and go to DECODE when MemReady=1.
REQ-016 DECODE SHALL go to MEMADR for lw/sw, EXEC for R-type, BRANCH for beq, and FETCH for any other opcode.
REQ-017 MEMADR SHALL go to MEMRD for lw and MEMWR for sw; MEMRD SHALL hold until MemReady=1, then go to MEMWB.
REQ-018 MEMWR SHALL hold until MemReady=1, then go to FETCH; EXEC SHALL go to ALUWB; MEMWB, ALUWB and BRANCH SHALL go to FETCH.
REQ-019 Outputs SHALL be combinational decodes of the state register; every output not listed for a state SHALL be 0.
REQ-020 FETCH outputs: MemRead=1, ALUSrcB=01, ALUOp=00; IRWrite=1 and PCWrite=1 only in the cycle MemReady=1.
REQ-021 DECODE outputs: ALUSrcB=11, ALUOp=00.
REQ-022 MEMADR outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-023 MEMRD outputs: MemRead=1, IorD=1.
REQ-024 MEMWB outputs: RegWrite=1, MemtoReg=1.
REQ-025 MEMWR outputs: MemWrite=1, IorD=1, held every cycle until MemReady=1.
REQ-026 EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-027 ALUWB outputs: RegWrite=1.
REQ-028 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=Zero (the only Mealy output).
REQ-029 Latency with MemReady=1 throughout SHALL be: lw 5 cycles, sw 4, R-type 4, beq 3, unsupported opcode 2.
REQ-030 Each MemReady=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency.
REQ-031 InstRet SHALL increment by 1 on the edge leaving MEMWB, ALUWB or BRANCH, and on the edge leaving MEMWR with MemReady=1.
REQ-032 InstRet SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 An unsupported opcode in DECODE SHALL set Illegal on that edge; Illegal SHALL stay set until reset, and the instruction SHALL NOT be counted.

Reset
REQ-034 On a rising edge with reset=0: State=FETCH, InstRet=0, Illegal=0.
REQ-035 While reset=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 combinationally.
REQ-036 Reset in the middle of an instruction SHALL abort it with no InstRet increment.

Structure
REQ-037 State encodings, the four opcode constants and the ALUOp encodings SHALL live in a shared package/header, also used by the ALU control decoder.
REQ-038 The state-to-control-output decode SHALL be one combinational sub-module, control_decode.
REQ-039 The next-state register and the counters SHALL stay in multicycle_control.

Verification
REQ-040 lw (0000011), MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 in state 4; InstRet 0->1.
REQ-041 beq with Zero=1, then beq with Zero=0 -> PCWrite=1 in BRANCH for the first only; InstRet=2.
REQ-042 sw with MemReady=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles; total latency 7 cycles.
REQ-043 Opcode 1111111 -> DECODE to FETCH, Illegal=1 and stays 1 over a following R-type; InstRet unchanged; ALUOp=10 in EXEC.
REQ-044 reset=0 asserted in MEMRD -> next edge State=0, InstRet=0, no RegWrite pulse.
REQ-045 InstRet preloaded to 0xFFFFFFFF via force, then an R-type retires -> InstRet=0x00000000.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle controller and the ALU control
// decoder: FSM state encodings, the supported opcode values, the ALUOp and
// ALU B-select encodings, and the bundle of datapath control lines.
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

  // FSM states; the numeric codes are visible on the debug State port.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8
  } state_e;

  // Supported instruction opcodes (instruction[6:0]).
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALUOp encodings seen by the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select encodings.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // Datapath control lines produced by the state decode.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       i_or_d;
    logic       alu_src_a;
    logic       pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for the four opcodes this controller knows how to sequence.
  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/control_decode.sv
// ----------------------------------------------------------------------------
// control_decode
// Combinational decode of the controller state into datapath control lines.
// Ports:
//   state      in   current FSM state
//   zero       in   ALU zero flag (qualifies the branch PC write)
//   mem_ready  in   memory access complete this cycle (qualifies fetch writes)
//   ctrl       out  bundle of datapath controls, all zero unless listed
// ----------------------------------------------------------------------------
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_e state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Every line defaults to zero so each state only names what it drives.
  // Unused state codes fall through with all controls inactive.
  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        // PC and IR are only updated once the instruction word has arrived.
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_BOFF;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        // The branch is taken by writing the target only when operands match.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = 1'b1;
        ctrl.pc_write  = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Main FSM of a multicycle RISC-V style datapath (R-type, lw, sw, beq), with
// a retired-instruction counter and a sticky illegal-opcode flag.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   Opcode     in   instruction[6:0] from the instruction register
//   Zero       in   ALU zero flag
//   MemReady   in   memory access complete this cycle
//   PCWrite .. PCSource, ALUSrcB, ALUOp   out  datapath controls
//   Illegal    out  sticky unsupported-opcode flag
//   InstRet    out  retired-instruction count (wraps)
//   State      out  current state code for debug
// ----------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic        PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        Illegal,
  output logic [31:0] InstRet,
  output logic [3:0]  State
);

  state_e      state_q, state_d;
  logic [31:0] inst_ret_q, inst_ret_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  ctrl_t       ctrl;

  // Next-state selection; any unassigned state code recovers to FETCH.
  always_comb begin
    state_d = ST_FETCH;
    unique case (state_q)
      ST_FETCH:  state_d = MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = ST_MEMADR;
        else if (Opcode == OP_RTYPE)            state_d = ST_EXEC;
        else if (Opcode == OP_BEQ)              state_d = ST_BRANCH;
        else                                    state_d = ST_FETCH;
      end
      ST_MEMADR: begin
        if (Opcode == OP_LW)      state_d = ST_MEMRD;
        else if (Opcode == OP_SW) state_d = ST_MEMWR;
        else                      state_d = ST_FETCH;
      end
      ST_MEMRD:  state_d = MemReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = MemReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_MEMWB,
      ST_ALUWB,
      ST_BRANCH: state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its last state; a store
  // only finishes once memory accepts the write.
  always_comb begin
    retire = (state_q == ST_MEMWB) || (state_q == ST_ALUWB) ||
             (state_q == ST_BRANCH) || ((state_q == ST_MEMWR) && MemReady);
    inst_ret_d = retire ? inst_ret_q + 32'd1 : inst_ret_q;
    illegal_d  = illegal_q | ((state_q == ST_DECODE) && !is_supported(Opcode));
  end

  // State and counters; reset aborts any in-flight instruction uncounted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      inst_ret_q <= 32'd0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_ret_q <= inst_ret_d;
      illegal_q  <= illegal_d;
    end
  end

  control_decode u_decode (
    .state     (state_q),
    .zero      (Zero),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  // Architectural write enables are suppressed while reset is held so that
  // nothing is corrupted before the state register settles.
  always_comb begin
    PCWrite  = ctrl.pc_write  & reset;
    IRWrite  = ctrl.ir_write  & reset;
    MemWrite = ctrl.mem_write & reset;
    RegWrite = ctrl.reg_write & reset;
    MemRead  = ctrl.mem_read;
    MemtoReg = ctrl.mem_to_reg;
    IorD     = ctrl.i_or_d;
    ALUSrcA  = ctrl.alu_src_a;
    PCSource = ctrl.pc_source;
    ALUSrcB  = ctrl.alu_src_b;
    ALUOp    = ctrl.alu_op;
  end

  assign Illegal = illegal_q;
  assign InstRet = inst_ret_q;
  assign State   = state_q;

endmodule
